// File: rtl/game_pkg.sv
// Shared types and default constants for the boss attack controller.
// Holds the attack FSM state encoding and a counter-width helper.
package game_pkg;

    localparam int COOLDOWN_FRAMES = 60;
    localparam int KID_HP_INIT     = 3;
    localparam int INVULN_FRAMES   = 30;
    localparam int ARM_TIMEOUT     = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COOLDOWN = 3'd1,
        FIRE     = 3'd2,
        ARM      = 3'd3,
        ACTIVE   = 3'd4,
        DEAD     = 3'd5
    } state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kid_health.sv
// Kid hit points and post-hit invulnerability window.
// Reports a look-ahead "dying" flag so the FSM can enter DEAD on the same edge.
module kid_health #(
    parameter int KID_HP_INIT   = game_pkg::KID_HP_INIT,
    parameter int INVULN_FRAMES = game_pkg::INVULN_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit_i,
    output logic [2:0] kid_hp_o,
    output logic       kid_invuln_o,
    output logic       kid_dead_o,
    output logic       dying_o
);
    import game_pkg::*;

    localparam int IW = cnt_w(INVULN_FRAMES + 1);

    logic [2:0]    hp_q, hp_d;
    logic [IW-1:0] inv_q, inv_d;
    logic          dead_q, dead_d;

    // A hit only lands when the window is closed and the kid still has HP.
    always_comb begin
        hp_d   = hp_q;
        inv_d  = inv_q;
        dead_d = dead_q;
        if (inv_q != '0) begin
            inv_d = inv_q - IW'(1);
        end else if (hit_i && (hp_q != 3'd0)) begin
            hp_d  = hp_q - 3'd1;
            inv_d = IW'(INVULN_FRAMES);
        end
        if (hp_d == 3'd0) begin
            dead_d = 1'b1;
        end
    end

    // Health state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q   <= 3'(KID_HP_INIT);
            inv_q  <= '0;
            dead_q <= 1'b0;
        end else begin
            hp_q   <= hp_d;
            inv_q  <= inv_d;
            dead_q <= dead_d;
        end
    end

    assign kid_hp_o     = hp_q;
    assign kid_invuln_o = (inv_q != '0);
    assign kid_dead_o   = dead_q;
    assign dying_o      = (hp_d == 3'd0);

endmodule

// File: rtl/boss_attack_ctrl.sv
// Boss bomb attack scheduler: cooldown, one-frame shoot, arm watchdog.
// Kid health lives in kid_health; its look-ahead death flag forces DEAD.
module boss_attack_ctrl #(
    parameter int COOLDOWN_FRAMES = game_pkg::COOLDOWN_FRAMES,
    parameter int KID_HP_INIT     = game_pkg::KID_HP_INIT,
    parameter int INVULN_FRAMES   = game_pkg::INVULN_FRAMES,
    parameter int ARM_TIMEOUT     = game_pkg::ARM_TIMEOUT
) (
    input  logic       frame_clk,
    input  logic       Reset_h,
    input  logic       game_en,
    input  logic       boss_alive,
    input  logic       NoBomb,
    input  logic       hitBomb,
    output logic       shoot,
    output logic [2:0] kid_hp,
    output logic       kid_invuln,
    output logic       kid_dead,
    output logic       arm_fault
);
    import game_pkg::*;

    localparam int CW = cnt_w(COOLDOWN_FRAMES);
    localparam int AW = cnt_w(ARM_TIMEOUT);

    localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_TIMEOUT - 1);

    state_e        st_q, st_d;
    logic [CW-1:0] cd_q, cd_d;
    logic [AW-1:0] arm_q, arm_d;
    logic          shoot_q, shoot_d;
    logic          fault_q, fault_d;
    logic          dying;
    logic          run;

    kid_health #(
        .KID_HP_INIT   (KID_HP_INIT),
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_kid_health (
        .clk          (frame_clk),
        .rst          (Reset_h),
        .hit_i        (hitBomb),
        .kid_hp_o     (kid_hp),
        .kid_invuln_o (kid_invuln),
        .kid_dead_o   (kid_dead),
        .dying_o      (dying)
    );

    assign run = game_en & boss_alive;

    // Next-state logic; a bomb in flight is always allowed to finish.
    always_comb begin
        st_d    = st_q;
        cd_d    = cd_q;
        arm_d   = arm_q;
        fault_d = fault_q;
        shoot_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (run && NoBomb) begin
                    st_d = COOLDOWN;
                    cd_d = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (!run) begin
                    st_d = IDLE;
                end else if (cd_q == '0) begin
                    st_d = FIRE;
                end else begin
                    cd_d = cd_q - CW'(1);
                end
            end
            FIRE: begin
                if (!run) begin
                    st_d = IDLE;
                end else begin
                    st_d    = ARM;
                    arm_d   = ARM_LOAD;
                    shoot_d = 1'b1;
                end
            end
            ARM: begin
                if (!NoBomb) begin
                    st_d = ACTIVE;
                end else if (!run) begin
                    st_d = IDLE;
                end else if (arm_q == '0) begin
                    fault_d = 1'b1;
                    st_d    = COOLDOWN;
                    cd_d    = CD_LOAD;
                end else begin
                    arm_d = arm_q - AW'(1);
                end
            end
            ACTIVE: begin
                if (NoBomb) begin
                    if (run) begin
                        st_d = COOLDOWN;
                        cd_d = CD_LOAD;
                    end else begin
                        st_d = IDLE;
                    end
                end
            end
            DEAD: begin
                st_d = DEAD;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
        if (dying) begin
            st_d    = DEAD;
            shoot_d = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset_h) begin
            st_q    <= IDLE;
            cd_q    <= '0;
            arm_q   <= '0;
            shoot_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cd_q    <= cd_d;
            arm_q   <= arm_d;
            shoot_q <= shoot_d;
            fault_q <= fault_d;
        end
    end

    assign shoot     = shoot_q;
    assign arm_fault = fault_q;

endmodule
